// File: rtl/crp16_defs_pkg.sv
// crp16_defs: shared widths and the writeback entry layout for the CRP16
// writeback path.
//   REG_SEL_W - register index width
//   DATA_W    - register data width
//   NUM_REGS  - architectural register count (one pending bit each)
//   wb_entry  - one queued register-file write {sel, val}
package crp16_defs;

  localparam int unsigned REG_SEL_W = 3;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned NUM_REGS  = 8;

  typedef struct packed {
    logic [REG_SEL_W-1:0] sel;
    logic [DATA_W-1:0]    val;
  } wb_entry;

endpackage

// File: rtl/crp16_sel_decode.sv
// crp16_sel_decode: 3-to-8 one-hot decoder with enable.
//   en     in  - when low the output is all zeros
//   sel    in  - register index
//   onehot out - bit sel set when en is high
module crp16_sel_decode
  import crp16_defs::*;
(
  input  logic                 en,
  input  logic [REG_SEL_W-1:0] sel,
  output logic [NUM_REGS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/crp16_writeback_queue.sv
// crp16_writeback_queue: in-order writeback FIFO in front of the CRP16
// register file's single write port.
//   clock, reset_n           - clock, asynchronous active-low reset
//   alu_valid/sel/val/ready  - ALU result handshake
//   mem_valid/sel/val/ready  - load result handshake (enqueued ahead of ALU)
//   write/write_sel/write_val - register file write port, head of queue
//   pending                  - per-register "write still queued" scoreboard
//   count                    - current occupancy, 0..DEPTH
module crp16_writeback_queue
  import crp16_defs::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 alu_valid,
  input  logic [REG_SEL_W-1:0] alu_sel,
  input  logic [DATA_W-1:0]    alu_val,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [REG_SEL_W-1:0] mem_sel,
  input  logic [DATA_W-1:0]    mem_val,
  output logic                 mem_ready,
  output logic                 write,
  output logic [REG_SEL_W-1:0] write_sel,
  output logic [DATA_W-1:0]    write_val,
  output logic [NUM_REGS-1:0]  pending,
  output logic [PTR_W:0]       count
);

  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FREE_W = PTR_W + 2;

  wb_entry              store [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [PTR_W-1:0]     alu_slot;
  logic                 pop;
  logic                 mem_push;
  logic                 alu_push;
  logic [1:0]           n_push;
  logic [FREE_W-1:0]    free;
  logic [NUM_REGS-1:0]  dec [DEPTH];

  // The register file never stalls, so a non-empty queue pops every cycle
  // and that slot is already usable by this cycle's pushes.
  always_comb begin
    pop       = (count != '0);
    free      = FREE_W'(DEPTH) - FREE_W'(count) + FREE_W'(pop);
    mem_ready = reset_n & (free >= FREE_W'(1));
    alu_ready = reset_n & (mem_valid ? (free >= FREE_W'(2)) : (free >= FREE_W'(1)));
    mem_push  = mem_valid & mem_ready;
    alu_push  = alu_valid & alu_ready;
    n_push    = {1'b0, mem_push} + {1'b0, alu_push};
    alu_slot  = mem_push ? (tail + PTR_W'(1)) : tail;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(n_push);
      count <= count + CNT_W'(n_push) - CNT_W'(pop);
    end
  end

  // Entry payload carries no reset; occupancy alone defines validity.
  always_ff @(posedge clock) begin
    if (mem_push) store[tail]     <= '{sel: mem_sel, val: mem_val};
    if (alu_push) store[alu_slot] <= '{sel: alu_sel, val: alu_val};
  end

  always_comb begin
    write     = pop;
    write_sel = pop ? store[head].sel : '0;
    write_val = pop ? store[head].val : '0;
  end

  // An entry is live when its distance from head is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic [PTR_W-1:0] offs;
    logic             live;

    always_comb begin
      offs = PTR_W'(g) - head;
      live = (CNT_W'(offs) < count);
    end

    crp16_sel_decode u_dec (
      .en     (live),
      .sel    (store[g].sel),
      .onehot (dec[g])
    );
  end

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) pending |= dec[i];
  end

endmodule

// File: tb/tb_crp16_writeback_queue.sv
module tb_crp16_writeback_queue;
  import crp16_defs::*;

  logic        clock;
  logic        reset_n;
  logic        alu_valid;
  logic [2:0]  alu_sel;
  logic [15:0] alu_val;
  logic        alu_ready;
  logic        mem_valid;
  logic [2:0]  mem_sel;
  logic [15:0] mem_val;
  logic        mem_ready;
  logic        write;
  logic [2:0]  write_sel;
  logic [15:0] write_val;
  logic [7:0]  pending;
  logic [2:0]  count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  wb_entry     wlog [$];
  wb_entry     exp_q [$];
  logic [15:0] rf [8];

  crp16_writeback_queue #(.DEPTH(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .alu_valid (alu_valid),
    .alu_sel   (alu_sel),
    .alu_val   (alu_val),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_sel   (mem_sel),
    .mem_val   (mem_val),
    .mem_ready (mem_ready),
    .write     (write),
    .write_sel (write_sel),
    .write_val (write_val),
    .pending   (pending),
    .count     (count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Register-file model: whatever is on the write port mid-cycle is
  // captured at the following rising edge.
  always @(negedge clock) begin
    if (reset_n && write) begin
      wlog.push_back('{sel: write_sel, val: write_val});
      rf[write_sel] = write_val;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_log(input string tag, input wb_entry exp[$]);
    check({tag, "_nwrites"}, 32'(wlog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < wlog.size())
        check($sformatf("%s_w%0d", tag, i), 32'(wlog[i]), 32'(exp[i]));
    end
  endtask

  function automatic wb_entry mk(input logic [2:0] s, input logic [15:0] v);
    return '{sel: s, val: v};
  endfunction

  initial begin
    int unsigned exp_cnt [6];
    logic        exp_ar  [6];
    exp_cnt = '{2, 3, 4, 4, 4, 4};
    exp_ar  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) rf[i] = '0;

    // Reset held with both producers offering.
    reset_n = 1'b0;
    alu_valid = 1'b1; alu_sel = 3'd6; alu_val = 16'hDEAD;
    mem_valid = 1'b1; mem_sel = 3'd7; mem_val = 16'hBEEF;
    #2;
    check("rst_write", 32'(write), 32'd0);
    check("rst_pending", 32'(pending), 32'h00);
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_write_val", 32'(write_val), 32'd0);
    tick();
    check("rst_edge_count", 32'(count), 32'd0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    reset_n = 1'b1;
    wlog.delete();

    // First push: single ALU result.
    alu_valid = 1'b1; alu_sel = 3'd3; alu_val = 16'h1234;
    #1;
    check("p1_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    check("p1_write", 32'(write), 32'd1);
    check("p1_write_sel", 32'(write_sel), 32'd3);
    check("p1_write_val", 32'(write_val), 32'h1234);
    check("p1_pending", 32'(pending), 32'h08);
    check("p1_count", 32'(count), 32'd1);
    tick();
    check("p1_pending_clr", 32'(pending), 32'h00);
    check("p1_count_clr", 32'(count), 32'd0);
    check("p1_write_clr", 32'(write), 32'd0);
    check("p1_write_sel_clr", 32'(write_sel), 32'd0);

    // Dual push in one cycle: mem drains before alu.
    wlog.delete();
    mem_valid = 1'b1; mem_sel = 3'd1; mem_val = 16'hAAAA;
    alu_valid = 1'b1; alu_sel = 3'd2; alu_val = 16'h5555;
    #1;
    check("dual_mem_ready", 32'(mem_ready), 32'd1);
    check("dual_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    check("dual_count0", 32'(count), 32'd2);
    check("dual_sel0", 32'(write_sel), 32'd1);
    check("dual_val0", 32'(write_val), 32'hAAAA);
    check("dual_pend0", 32'(pending), 32'h06);
    tick();
    check("dual_count1", 32'(count), 32'd1);
    check("dual_sel1", 32'(write_sel), 32'd2);
    check("dual_val1", 32'(write_val), 32'h5555);
    check("dual_pend1", 32'(pending), 32'h04);
    tick();
    check("dual_pend2", 32'(pending), 32'h00);
    check("dual_write2", 32'(write), 32'd0);
    exp_q.delete();
    exp_q.push_back(mk(3'd1, 16'hAAAA));
    exp_q.push_back(mk(3'd2, 16'h5555));
    check_log("dual", exp_q);

    // Full throttle: both valid for six cycles.
    wlog.delete();
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      mem_valid = 1'b1; mem_sel = 3'(k);     mem_val = 16'h1000 + 16'(k);
      alu_valid = 1'b1; alu_sel = 3'(k + 4); alu_val = 16'hA000 + 16'(k);
      #1;
      check($sformatf("full_mem_ready%0d", k), 32'(mem_ready), 32'd1);
      check($sformatf("full_alu_ready%0d", k), 32'(alu_ready), 32'(exp_ar[k]));
      tick();
      check($sformatf("full_count%0d", k), 32'(count), 32'(exp_cnt[k]));
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("full_drain%0d", k), 32'(count), 32'(3 - k));
    end
    exp_q.push_back(mk(3'd0, 16'h1000));
    exp_q.push_back(mk(3'd4, 16'hA000));
    exp_q.push_back(mk(3'd1, 16'h1001));
    exp_q.push_back(mk(3'd5, 16'hA001));
    exp_q.push_back(mk(3'd2, 16'h1002));
    exp_q.push_back(mk(3'd6, 16'hA002));
    exp_q.push_back(mk(3'd3, 16'h1003));
    exp_q.push_back(mk(3'd4, 16'h1004));
    exp_q.push_back(mk(3'd5, 16'h1005));
    check_log("full", exp_q);

    // Same destination twice: last write wins.
    wlog.delete();
    alu_valid = 1'b1; alu_sel = 3'd5; alu_val = 16'h0001;
    tick();
    alu_valid = 1'b0;
    check("same_pend0", 32'(pending), 32'h20);
    check("same_val0", 32'(write_val), 32'h0001);
    mem_valid = 1'b1; mem_sel = 3'd5; mem_val = 16'h0002;
    tick();
    mem_valid = 1'b0;
    check("same_pend1", 32'(pending), 32'h20);
    check("same_val1", 32'(write_val), 32'h0002);
    check("same_count1", 32'(count), 32'd1);
    tick();
    check("same_pend2", 32'(pending), 32'h00);
    check("same_rf5", 32'(rf[5]), 32'h0002);
    exp_q.delete();
    exp_q.push_back(mk(3'd5, 16'h0001));
    exp_q.push_back(mk(3'd5, 16'h0002));
    check_log("same", exp_q);

    // Wrap-around: nine single entries pushed and drained.
    wlog.delete();
    exp_q.delete();
    for (int k = 0; k < 9; k++) begin
      alu_valid = 1'b1; alu_sel = 3'(k); alu_val = 16'hC000 + 16'(k);
      tick();
      alu_valid = 1'b0;
      check($sformatf("wrap_val%0d", k), 32'(write_val), 32'(16'hC000 + 16'(k)));
      check($sformatf("wrap_cnt%0d", k), 32'(count), 32'd1);
      tick();
      exp_q.push_back(mk(3'(k), 16'hC000 + 16'(k)));
    end
    check("wrap_count_end", 32'(count), 32'd0);
    check_log("wrap", exp_q);

    // Reset mid-operation with three entries queued.
    wlog.delete();
    mem_valid = 1'b1; mem_sel = 3'd1; mem_val = 16'h1111;
    alu_valid = 1'b1; alu_sel = 3'd2; alu_val = 16'h2222;
    tick();
    mem_sel = 3'd3; mem_val = 16'h3333;
    alu_sel = 3'd4; alu_val = 16'h4444;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    check("mid_count3", 32'(count), 32'd3);
    check("mid_write", 32'(write), 32'd1);
    check("mid_pend", 32'(pending), 32'h1C);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_write", 32'(write), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_pend", 32'(pending), 32'h00);
    check("mid_rst_mem_ready", 32'(mem_ready), 32'd0);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mid_idle_write%0d", k), 32'(write), 32'd0);
    end
    exp_q.delete();
    exp_q.push_back(mk(3'd1, 16'h1111));
    check_log("mid", exp_q);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
